mod_vga_fetch: RTL and testbench
================================

# mod_vga_fetch

Framebuffer prefetch engine between the SRAM controller's VGA bypass port and the VGA scan-out logic. It walks the framebuffer linearly from a base address once per frame and issues one 32-bit read at a time over the bypass handshake. Returned words go into a small FIFO that the scan-out side pops one pixel word at a time. It keeps the bypass request line low whenever the FIFO cannot accept a word, so CPU stalls caused by VGA traffic stay bounded.

## Interface
Parameters:
- FIFO_DEPTH, 8: FIFO entries; power of two, minimum 2.
- FRAME_WORDS, 76800: 32-bit words fetched per frame.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- fb_base  in  32  framebuffer byte address; sampled on frame_start; bits [1:0] ignored (treated as 0).
- frame_start  in  1  one-cycle pulse from VGA timing that begins a new frame.
- pix_pop  in  1  scan-out consumes the head word this cycle.
- pix_data  out  32  FIFO head word (first-word fall-through); holds its last value when the FIFO is empty.
- pix_valid  out  1  FIFO not empty.
- underrun  out  1  sticky: a pop was attempted while empty; cleared by frame_start.
- mod_vga_sram_addr  out  32  read address; held stable while mod_vga_sram_read is high.
- mod_vga_sram_read  out  1  bypass request level.
- mod_vga_sram_rdy  in  1  bypass completion; may stay high for more than one cycle.
- mod_vga_sram_data  in  32  read data; valid when mod_vga_sram_rdy is high.

## Operation
- Reset values: mod_vga_sram_read=0, mod_vga_sram_addr=0, pix_valid=0, pix_data=0, underrun=0, FIFO empty, state IDLE, word counter 0.
- States:
  - IDLE: no frame is active.
  - REQ: mod_vga_sram_read=1, waiting for rdy.
  - GAP: read=0 for exactly one cycle, so the controller does not re-trigger on a stale level.
  - DONE: the frame is fully fetched.
- Transitions:
  - IDLE or DONE -> REQ, or -> GAP when the FIFO has no free slot, on frame_start. The block latches addr=fb_base&~3 and words_left=FRAME_WORDS.
  - GAP -> REQ when words_left>0 and FIFO count<FIFO_DEPTH. Otherwise it stays in GAP, or goes to DONE when words_left=0.
  - REQ -> GAP on the first rising edge with rdy=1. On that edge: push the data, addr+=4 (32-bit wrap), words_left-=1.
- Credit rule: a request is issued only if a FIFO slot is free. Only one request is ever outstanding, so a push never overflows.
- frame_start while in REQ: the in-flight SRAM access cannot be aborted.
  - The FIFO flushes immediately and the new base and count are latched.
  - A discard flag is set, and the data from the next rdy is dropped (no push, no counter change).
  - The block then goes GAP -> REQ at the new base.
- frame_start in GAP: flush, reload, and continue from the new base.
- frame_start while underrun=1: underrun clears.
- Simultaneous push and pop: count is unchanged and both take effect.
- Pop when empty: no FIFO change, underrun<=1, pix_data unchanged.
- Reset asserted mid-request: everything clears asynchronously and read drops at once. The controller finishes its access and its rdy is ignored, because the block is in IDLE.

## Timing
- frame_start at edge N: mod_vga_sram_read=1 after edge N, with the address set to the new base.
- rdy sampled high at edge M:
  - word is visible at pix_data/pix_valid after edge M when the FIFO was empty;
  - read=0 after edge M;
  - next read=1 after edge M+1 at the earliest.
- Minimum spacing between requests: 2 cycles plus the controller's access time.
- pix_pop at edge K: the next head word appears after edge K.

## Structure
- Shared package: the address stride constant (4) and state encodings (IDLE=2'b00, REQ=2'b01, GAP=2'b10, DONE=2'b11).
- Sub-module: vga_fetch_fifo.
  - Synchronous FWFT FIFO with parameter DEPTH.
  - Ports push, pop, wdata, rdata, count, flush; same clk and rst.
  - flush has priority over push.
- Top level: state machine, address and word counters, discard flag, underrun flag.

## Test plan
- Basic fetch: reset, FRAME_WORDS=4, fb_base=0x1000, frame_start, rdy model with 4-cycle latency and data=address, no pops -> addresses 0x1000, 0x1004, 0x1008, 0x100C; FIFO holds 0x1000..0x100C; state DONE; read stays 0.
- Backpressure: FIFO_DEPTH=2, FRAME_WORDS=8, no pops -> exactly 2 requests, then read stays 0. One pix_pop -> one further request at 0x1008.
- Restart mid-request: frame_start with fb_base=0x2000 while read=1 at 0x1004 -> the returned 0x1004 word is discarded; the next request is 0x2000; pix_data first shows 0x2000.
- Underrun: pop on an empty FIFO -> underrun=1 and pix_data unchanged. Next frame_start -> underrun=0.
- Simultaneous push/pop: with count=1, rdy and pix_pop land on the same edge -> count stays 1 and the head becomes the new word.
- Async reset: drop rst during REQ -> read=0 immediately; all outputs return to reset values; a late rdy causes no push.

Source files
------------

// File: rtl/mod_vga_fetch_pkg.sv
// Shared constants and state encoding for the VGA framebuffer prefetch engine.
package mod_vga_fetch_pkg;

    // Byte stride between consecutive 32-bit framebuffer words.
    localparam logic [31:0] ADDR_STRIDE = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_GAP  = 2'b10,
        ST_DONE = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/mod_vga_fetch_fifo.sv
// First-word fall-through FIFO for fetched pixel words. The head word is
// registered so it holds its last value once the FIFO drains.
module vga_fetch_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_nxt;
    logic [AW:0]   cnt;
    logic [31:0]   head;
    logic          do_push;
    logic          do_pop;

    // Effective push/pop: flush wins, pops on empty and pushes on full are dropped.
    always_comb begin
        rd_nxt  = rd_ptr + AW'(1);
        do_pop  = pop && (cnt != '0) && !flush;
        do_push = push && !flush && ((cnt != (AW+1)'(DEPTH)) || do_pop);
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and registered head word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_nxt;
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - (AW+1)'(1);
            end
            // Head follows the next stored word, or the incoming word when
            // it becomes the only entry.
            if (do_pop) begin
                if (cnt > (AW+1)'(1)) begin
                    head <= mem[rd_nxt];
                end else if (do_push) begin
                    head <= wdata;
                end
            end else if (do_push && (cnt == '0)) begin
                head <= wdata;
            end
        end
    end

    assign rdata = head;
    assign count = cnt;

endmodule

// File: rtl/mod_vga_fetch.sv
// Framebuffer prefetch engine: walks the framebuffer once per frame over the
// SRAM bypass port, one read in flight, and buffers words for scan-out.
module mod_vga_fetch
    import mod_vga_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int FRAME_WORDS = 76800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fb_base,
    input  logic        frame_start,
    input  logic        pix_pop,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    output logic        underrun,
    output logic [31:0] mod_vga_sram_addr,
    output logic        mod_vga_sram_read,
    input  logic        mod_vga_sram_rdy,
    input  logic [31:0] mod_vga_sram_data
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = $clog2(FRAME_WORDS + 1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [WW-1:0] words_q, words_d;
    logic          disc_q, disc_d;
    logic          under_q;
    logic          fifo_push;
    logic          fifo_flush;
    logic [CW-1:0] fifo_count;
    logic          slot_free;
    logic [31:0]   base_aligned;

    assign base_aligned = fb_base & ~32'd3;
    assign slot_free    = fifo_count < CW'(FIFO_DEPTH);

    vga_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (pix_pop),
        .flush (fifo_flush),
        .wdata (mod_vga_sram_data),
        .rdata (pix_data),
        .count (fifo_count)
    );

    // Next-state, address/counter updates and FIFO control.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        req_addr_d = req_addr_q;
        words_d    = words_q;
        disc_d     = disc_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (frame_start) begin
                    addr_d  = base_aligned;
                    words_d = WW'(FRAME_WORDS);
                    if (slot_free) begin
                        state_d    = ST_REQ;
                        req_addr_d = base_aligned;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_REQ: begin
                if (frame_start) begin
                    // In-flight access cannot be aborted: keep the request
                    // address stable and drop its data when it returns. A
                    // completion on this same edge is dropped directly.
                    fifo_flush = 1'b1;
                    addr_d     = base_aligned;
                    words_d    = WW'(FRAME_WORDS);
                    if (mod_vga_sram_rdy) begin
                        state_d = ST_GAP;
                        disc_d  = 1'b0;
                    end else begin
                        disc_d = 1'b1;
                    end
                end else if (mod_vga_sram_rdy) begin
                    state_d = ST_GAP;
                    if (disc_q) begin
                        disc_d = 1'b0;
                    end else begin
                        fifo_push = 1'b1;
                        addr_d    = addr_q + ADDR_STRIDE;
                        words_d   = words_q - WW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (frame_start) begin
                    fifo_flush = 1'b1;
                    addr_d     = base_aligned;
                    words_d    = WW'(FRAME_WORDS);
                    state_d    = ST_REQ;
                    req_addr_d = base_aligned;
                end else if (words_q == '0) begin
                    state_d = ST_DONE;
                end else if (slot_free) begin
                    state_d    = ST_REQ;
                    req_addr_d = addr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, address, word counter and discard flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            req_addr_q <= '0;
            words_q    <= '0;
            disc_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            req_addr_q <= req_addr_d;
            words_q    <= words_d;
            disc_q     <= disc_d;
        end
    end

    // Sticky underrun: set by a pop on empty, cleared at each frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            under_q <= 1'b0;
        end else if (frame_start) begin
            under_q <= 1'b0;
        end else if (pix_pop && !pix_valid) begin
            under_q <= 1'b1;
        end
    end

    assign pix_valid         = fifo_count != '0;
    assign underrun          = under_q;
    assign mod_vga_sram_read = state_q == ST_REQ;
    assign mod_vga_sram_addr = req_addr_q;

endmodule

// File: tb/tb_mod_vga_fetch.sv
// Self-checking bench for mod_vga_fetch: directed scenarios plus randomized
// traffic checked against a queue-based behavioural model.
module tb_mod_vga_fetch;
    localparam int DEPTH = 4;
    localparam int FW    = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fb_base;
    logic        frame_start;
    logic        pix_pop;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        underrun;
    logic [31:0] mod_vga_sram_addr;
    logic        mod_vga_sram_read;
    logic        mod_vga_sram_rdy;
    logic [31:0] mod_vga_sram_data;

    always #5 clk = ~clk;

    mod_vga_fetch #(
        .FIFO_DEPTH  (DEPTH),
        .FRAME_WORDS (FW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .fb_base           (fb_base),
        .frame_start       (frame_start),
        .pix_pop           (pix_pop),
        .pix_data          (pix_data),
        .pix_valid         (pix_valid),
        .underrun          (underrun),
        .mod_vga_sram_addr (mod_vga_sram_addr),
        .mod_vga_sram_read (mod_vga_sram_read),
        .mod_vga_sram_rdy  (mod_vga_sram_rdy),
        .mod_vga_sram_data (mod_vga_sram_data)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: FIFO as a queue, frame progress as a word count.
    logic [31:0] q[$];
    logic [31:0] m_data;
    logic        m_under;
    bit          m_disc;
    bit          m_started;
    bit          m_just_done;
    int          m_acc;
    logic [31:0] m_base;

    // SRAM responder and per-cycle observations.
    bit          auto_resp;
    bit          rand_data;
    bit          hold_en;
    bit          hold_pend;
    int          lat;
    int          lat_cnt;
    logic        read_pre;
    logic [31:0] addr_pre;
    bit          rose;
    bit          completed;
    logic [31:0] req_log[$];

    task automatic model_reset();
        q.delete();
        req_log.delete();
        m_data      = '0;
        m_under     = 1'b0;
        m_disc      = 0;
        m_started   = 0;
        m_just_done = 0;
        m_acc       = 0;
        m_base      = '0;
        lat_cnt     = 0;
        hold_pend   = 0;
    endtask

    // One clock: responder decides rdy, edge, then model advances.
    task automatic tick();
        bit flushing;
        if (auto_resp) begin
            if (hold_pend) begin
                mod_vga_sram_rdy = 1'b1;
                hold_pend = 0;
            end else if (mod_vga_sram_read) begin
                lat_cnt++;
                if (lat_cnt >= lat) begin
                    mod_vga_sram_rdy  = 1'b1;
                    mod_vga_sram_data = rand_data ? $urandom : mod_vga_sram_addr;
                    lat_cnt = 0;
                    hold_pend = hold_en && ($urandom_range(1) == 1);
                end else begin
                    mod_vga_sram_rdy = 1'b0;
                end
            end else begin
                mod_vga_sram_rdy = 1'b0;
                lat_cnt = 0;
            end
        end
        read_pre = mod_vga_sram_read;
        addr_pre = mod_vga_sram_addr;
        @(posedge clk);
        #1;
        completed = read_pre && mod_vga_sram_rdy;
        if (frame_start) begin
            flushing = m_started && (m_acc < FW || m_just_done);
            if (flushing) begin
                q.delete();
                m_disc = read_pre && !mod_vga_sram_rdy;
            end else if (pix_pop && q.size() > 0) begin
                void'(q.pop_front());
            end
            m_base      = fb_base & ~32'd3;
            m_acc       = 0;
            m_started   = 1;
            m_under     = 1'b0;
            m_just_done = 0;
        end else begin
            m_just_done = 0;
            if (pix_pop) begin
                if (q.size() > 0) void'(q.pop_front());
                else m_under = 1'b1;
            end
            if (completed) begin
                if (m_disc) begin
                    m_disc = 0;
                end else begin
                    q.push_back(mod_vga_sram_data);
                    m_acc++;
                    if (m_acc == FW) m_just_done = 1;
                end
            end
        end
        if (q.size() > 0) m_data = q[0];
        rose = mod_vga_sram_read && !read_pre;
        if (rose) req_log.push_back(mod_vga_sram_addr);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        fb_base = '0;
        frame_start = 1'b0;
        pix_pop = 1'b0;
        mod_vga_sram_rdy = 1'b0;
        mod_vga_sram_data = '0;
        auto_resp = 0;
        rand_data = 0;
        hold_en = 0;
        lat = 4;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (mod_vga_sram_read !== 1'b0) begin n_err++; $display("FAIL reset_read: got %b expected 0", mod_vga_sram_read); end
        n_vec++; if (mod_vga_sram_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", mod_vga_sram_addr); end
        n_vec++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
        n_vec++; if (pix_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", pix_data); end
        n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        repeat (3) tick();
        n_vec++; if (mod_vga_sram_read !== 1'b0) begin n_err++; $display("FAIL idle_read: got %b expected 0", mod_vga_sram_read); end
    endtask

    task automatic test_basic_fetch();
        logic [31:0] exp;
        int guard;
        do_reset();
        auto_resp = 1;
        lat = 4;
        fb_base = 32'h0000_1003;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_vec++; if (mod_vga_sram_read !== 1'b1) begin n_err++; $display("FAIL start_read: got %b expected 1", mod_vga_sram_read); end
        n_vec++; if (mod_vga_sram_addr !== 32'h1000) begin n_err++; $display("FAIL start_addr: got %h expected 00001000", mod_vga_sram_addr); end
        repeat (40) tick();
        n_vec++; if (req_log.size() != DEPTH) begin n_err++; $display("FAIL credit_reqs: got %0d expected %0d", req_log.size(), DEPTH); end
        for (int k = 0; k < DEPTH; k++) begin
            exp = 32'h1000 + 32'(4 * k);
            n_vec++;
            if (k >= req_log.size() || req_log[k] !== exp) begin
                n_err++; $display("FAIL req_addr[%0d]: got %h expected %h", k, (k < req_log.size()) ? req_log[k] : 32'hx, exp);
            end
        end
        n_vec++; if (pix_valid !== 1'b1 || pix_data !== 32'h1000) begin n_err++; $display("FAIL full_head: got %b/%h expected 1/00001000", pix_valid, pix_data); end
        n_vec++; if (mod_vga_sram_read !== 1'b0) begin n_err++; $display("FAIL full_read: got %b expected 0", mod_vga_sram_read); end
        pix_pop = 1'b1;
        tick();
        pix_pop = 1'b0;
        n_vec++; if (pix_data !== 32'h1004) begin n_err++; $display("FAIL pop_head: got %h expected 00001004", pix_data); end
        repeat (20) tick();
        n_vec++; if (req_log.size() != DEPTH + 1 || req_log[DEPTH] !== 32'h1010) begin
            n_err++; $display("FAIL credit_refill: got %0d reqs last %h expected %0d reqs last 00001010", req_log.size(), req_log[req_log.size()-1], DEPTH + 1);
        end
        exp = 32'h1004;
        guard = 0;
        while (exp != 32'h1000 + 32'(4 * FW) && guard < 200) begin
            if (pix_valid) begin
                n_vec++; if (pix_data !== exp) begin n_err++; $display("FAIL drain_data: got %h expected %h", pix_data, exp); end
                exp += 32'd4;
                pix_pop = 1'b1;
            end else begin
                pix_pop = 1'b0;
            end
            tick();
            guard++;
        end
        pix_pop = 1'b0;
        n_vec++; if (exp !== 32'h1000 + 32'(4 * FW)) begin n_err++; $display("FAIL drain_count: got %h expected %h", exp, 32'h1000 + 32'(4 * FW)); end
        repeat (10) tick();
        n_vec++; if (mod_vga_sram_read !== 1'b0 || req_log.size() != FW) begin
            n_err++; $display("FAIL done_idle: got read %b reqs %0d expected read 0 reqs %0d", mod_vga_sram_read, req_log.size(), FW);
        end
    endtask

    task automatic test_restart();
        bit found;
        do_reset();
        auto_resp = 1;
        lat = 4;
        fb_base = 32'h1000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (rose && mod_vga_sram_addr === 32'h1004) found = 1;
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL restart_wait: got no request at 00001004 expected one"); end
        fb_base = 32'h2000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_vec++; if (mod_vga_sram_read !== 1'b1 || mod_vga_sram_addr !== 32'h1004) begin
            n_err++; $display("FAIL restart_inflight: got %b/%h expected 1/00001004", mod_vga_sram_read, mod_vga_sram_addr);
        end
        n_vec++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL restart_flush: got %b expected 0", pix_valid); end
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (rose) found = 1;
        end
        n_vec++; if (!found || mod_vga_sram_addr !== 32'h2000) begin n_err++; $display("FAIL restart_addr: got %h expected 00002000", mod_vga_sram_addr); end
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (pix_valid) found = 1;
        end
        n_vec++; if (!found || pix_data !== 32'h2000) begin n_err++; $display("FAIL restart_head: got %h expected 00002000", pix_data); end
    endtask

    task automatic test_underrun();
        int popped;
        do_reset();
        auto_resp = 1;
        lat = 1;
        fb_base = 32'h3000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        popped = 0;
        for (int i = 0; i < 100 && popped < FW; i++) begin
            pix_pop = pix_valid;
            if (pix_valid) popped++;
            tick();
        end
        pix_pop = 1'b0;
        repeat (5) tick();
        n_vec++; if (pix_valid !== 1'b0 || pix_data !== 32'h3014 || underrun !== 1'b0) begin
            n_err++; $display("FAIL underrun_pre: got %b/%h/%b expected 0/00003014/0", pix_valid, pix_data, underrun);
        end
        pix_pop = 1'b1;
        tick();
        pix_pop = 1'b0;
        n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_set: got %b expected 1", underrun); end
        n_vec++; if (pix_data !== 32'h3014) begin n_err++; $display("FAIL underrun_hold: got %h expected 00003014", pix_data); end
        tick();
        n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_sticky: got %b expected 1", underrun); end
        fb_base = 32'h3100;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL underrun_clear: got %b expected 0", underrun); end
    endtask

    task automatic test_push_pop();
        do_reset();
        fb_base = 32'h4000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        mod_vga_sram_rdy = 1'b1;
        mod_vga_sram_data = 32'h4000;
        tick();
        mod_vga_sram_rdy = 1'b0;
        n_vec++; if (pix_valid !== 1'b1 || pix_data !== 32'h4000 || mod_vga_sram_read !== 1'b0) begin
            n_err++; $display("FAIL first_word: got %b/%h read %b expected 1/00004000 read 0", pix_valid, pix_data, mod_vga_sram_read);
        end
        tick();
        n_vec++; if (mod_vga_sram_read !== 1'b1 || mod_vga_sram_addr !== 32'h4004) begin
            n_err++; $display("FAIL gap_then_req: got %b/%h expected 1/00004004", mod_vga_sram_read, mod_vga_sram_addr);
        end
        mod_vga_sram_rdy = 1'b1;
        mod_vga_sram_data = 32'h4004;
        pix_pop = 1'b1;
        tick();
        mod_vga_sram_rdy = 1'b0;
        pix_pop = 1'b0;
        n_vec++; if (pix_valid !== 1'b1 || pix_data !== 32'h4004) begin n_err++; $display("FAIL pushpop_head: got %b/%h expected 1/00004004", pix_valid, pix_data); end
        pix_pop = 1'b1;
        tick();
        pix_pop = 1'b0;
        n_vec++; if (pix_valid !== 1'b0 || underrun !== 1'b0) begin n_err++; $display("FAIL pushpop_count: got valid %b underrun %b expected 0/0", pix_valid, underrun); end
    endtask

    task automatic test_async_reset();
        do_reset();
        fb_base = 32'h5000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        mod_vga_sram_rdy = 1'b1;
        mod_vga_sram_data = 32'h5000;
        tick();
        mod_vga_sram_rdy = 1'b0;
        tick();
        n_vec++; if (mod_vga_sram_read !== 1'b1) begin n_err++; $display("FAIL areset_pre: got %b expected 1", mod_vga_sram_read); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (mod_vga_sram_read !== 1'b0 || mod_vga_sram_addr !== 32'h0) begin
            n_err++; $display("FAIL areset_read: got %b/%h expected 0/00000000", mod_vga_sram_read, mod_vga_sram_addr);
        end
        n_vec++; if (pix_valid !== 1'b0 || pix_data !== 32'h0 || underrun !== 1'b0) begin
            n_err++; $display("FAIL areset_outs: got %b/%h/%b expected 0/00000000/0", pix_valid, pix_data, underrun);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        mod_vga_sram_rdy = 1'b1;
        mod_vga_sram_data = 32'hDEAD_BEEF;
        tick();
        mod_vga_sram_rdy = 1'b0;
        tick();
        n_vec++; if (pix_valid !== 1'b0 || pix_data !== 32'h0 || mod_vga_sram_read !== 1'b0) begin
            n_err++; $display("FAIL late_rdy: got %b/%h read %b expected 0/00000000 read 0", pix_valid, pix_data, mod_vga_sram_read);
        end
    endtask

    task automatic test_random();
        int pop_pct;
        int guard;
        do_reset();
        auto_resp = 1;
        rand_data = 1;
        hold_en = 1;
        for (int ph = 0; ph < 6; ph++) begin
            pop_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 90);
            lat = $urandom_range(5, 1);
            for (int c = 0; c < 500; c++) begin
                frame_start = (c == 0 && ph == 0) || ($urandom_range(99) == 0);
                fb_base = $urandom;
                pix_pop = $urandom_range(99) < pop_pct;
                tick();
                n_vec++; if (pix_valid !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid: got %b expected %b", pix_valid, q.size() > 0); end
                n_vec++; if (pix_data !== m_data) begin n_err++; $display("FAIL rnd_data: got %h expected %h", pix_data, m_data); end
                n_vec++; if (underrun !== m_under) begin n_err++; $display("FAIL rnd_underrun: got %b expected %b", underrun, m_under); end
                if (rose) begin
                    n_vec++; if (mod_vga_sram_addr !== m_base + 32'(4 * m_acc)) begin
                        n_err++; $display("FAIL rnd_req_addr: got %h expected %h", mod_vga_sram_addr, m_base + 32'(4 * m_acc));
                    end
                    n_vec++; if (q.size() >= DEPTH || m_acc >= FW) begin
                        n_err++; $display("FAIL rnd_credit: got request with %0d queued %0d fetched expected fewer than %0d/%0d", q.size(), m_acc, DEPTH, FW);
                    end
                end
                if (completed) begin
                    n_vec++; if (mod_vga_sram_read !== 1'b0) begin n_err++; $display("FAIL rnd_gap: got read %b expected 0", mod_vga_sram_read); end
                end else if (read_pre && mod_vga_sram_read) begin
                    n_vec++; if (mod_vga_sram_addr !== addr_pre) begin n_err++; $display("FAIL rnd_addr_stable: got %h expected %h", mod_vga_sram_addr, addr_pre); end
                end
            end
        end
        frame_start = 1'b0;
        guard = 0;
        while (!(m_acc == FW && q.size() == 0 && !mod_vga_sram_read) && guard < 600) begin
            pix_pop = pix_valid;
            tick();
            guard++;
        end
        pix_pop = 1'b0;
        n_vec++; if (m_acc != FW || pix_valid !== 1'b0 || mod_vga_sram_read !== 1'b0) begin
            n_err++; $display("FAIL rnd_complete: got %0d words valid %b read %b expected %0d words valid 0 read 0", m_acc, pix_valid, mod_vga_sram_read, FW);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_fetch();
        test_restart();
        test_underrun();
        test_push_pop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
